// File: rtl/pld_scrambler.sv
// ----------------------------------------------------------------------------
// pld_scrambler
//
// Frames the serial PSDU bit stream as the 802.11a DATA field and scrambles it.
// Frame layout: SVC_BITS SERVICE zeros, 8*len PSDU bits, TAIL_BITS tail bits,
// then pad bits up to a whole number of OFDM symbols (N_DBPS bits each).
// Everything is scrambled with the x^7+x^4+1 LFSR; the tail bits are forced to
// zero after scrambling so the convolutional encoder returns to state zero.
//
// Ports:
//   clk     working clock
//   rst     asynchronous reset, active-low
//   start   one-cycle pulse: begin a frame, samples len/rate/seed
//   len     PSDU length in bytes
//   rate    802.11a RATE code, selects N_DBPS
//   seed    initial scrambler state (0 is replaced by 7'h7F)
//   di      PSDU bit from the payload generator
//   di_vld  di valid
//   di_rdy  block accepts di this cycle (registered)
//   dout    scrambled data bit ("do" is a reserved word in SystemVerilog)
//   do_vld  dout valid
//   busy    frame in progress
//   done    one-cycle pulse the cycle after the last pad bit leaves
//   err     sticky protocol error flag, cleared only by reset
// ----------------------------------------------------------------------------
module pld_scrambler #(
    parameter int SVC_BITS  = 16,
    parameter int TAIL_BITS = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] len,
    input  logic [3:0]  rate,
    input  logic [6:0]  seed,
    input  logic        di,
    input  logic        di_vld,
    output logic        di_rdy,
    output logic        dout,
    output logic        do_vld,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SERVICE = 3'd1,
        ST_DATA    = 3'd2,
        ST_TAIL    = 3'd3,
        ST_PAD     = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    // Shared SERVICE/TAIL position counter; wide enough for either field up to 32 bits.
    localparam int PHASE_W = 5;
    localparam logic [PHASE_W-1:0] SVC_LAST  = PHASE_W'(SVC_BITS - 1);
    localparam logic [PHASE_W-1:0] TAIL_LAST = PHASE_W'(TAIL_BITS - 1);

    // N_DBPS for a RATE code; zero marks an invalid code.
    function automatic logic [7:0] ndbps_lookup(input logic [3:0] code);
        logic [7:0] n;
        case (code)
            4'b1101: n = 8'd24;
            4'b1111: n = 8'd36;
            4'b0101: n = 8'd48;
            4'b0111: n = 8'd72;
            4'b1001: n = 8'd96;
            4'b1011: n = 8'd144;
            4'b0001: n = 8'd192;
            4'b0011: n = 8'd216;
            default: n = 8'd0;
        endcase
        return n;
    endfunction

    // Feedback tap of the x^7+x^4+1 scrambler.
    function automatic logic lfsr_fb(input logic [6:0] s);
        return s[6] ^ s[3];
    endfunction

    state_t             state_r;
    state_t             state_nxt_s;
    logic [6:0]         lfsr_r;
    logic [7:0]         ndbps_r;
    logic [18:0]        data_tgt_r;
    logic [18:0]        data_cnt_r;
    logic [18:0]        data_cnt_nxt_s;
    logic [PHASE_W-1:0] phase_cnt_r;
    logic [PHASE_W-1:0] phase_nxt_s;
    logic [7:0]         sym_cnt_r;

    logic [7:0]         ndbps_s;
    logic               rate_ok_s;
    logic               launch_s;
    logic               fb_s;
    logic               sym_last_s;
    logic               emit_s;
    logic               in_bit_s;
    logic               force_zero_s;
    logic               err_evt_s;

    logic               dout_r;
    logic               do_vld_r;
    logic               di_rdy_r;
    logic               busy_r;
    logic               done_r;
    logic               err_r;

    assign ndbps_s    = ndbps_lookup(rate);
    assign rate_ok_s  = (ndbps_s != 8'd0);
    assign launch_s   = (state_r == ST_IDLE) && start && rate_ok_s;
    assign fb_s       = lfsr_fb(lfsr_r);
    assign sym_last_s = (sym_cnt_r == (ndbps_r - 8'd1));

    // Protocol violations: start outside IDLE, start with a bad rate, di_vld outside DATA.
    assign err_evt_s  = (start && ((state_r != ST_IDLE) || !rate_ok_s)) ||
                        (di_vld && (state_r != ST_DATA));

    // Next-state logic and per-cycle emit decision.
    always_comb begin
        state_nxt_s    = state_r;
        phase_nxt_s    = phase_cnt_r;
        data_cnt_nxt_s = data_cnt_r;
        emit_s         = 1'b0;
        in_bit_s       = 1'b0;
        force_zero_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                phase_nxt_s    = {PHASE_W{1'b0}};
                data_cnt_nxt_s = 19'd0;
                if (launch_s) begin
                    state_nxt_s = ST_SERVICE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                emit_s = 1'b1;
                if (phase_cnt_r == SVC_LAST) begin
                    phase_nxt_s = {PHASE_W{1'b0}};
                    // An empty PSDU goes straight from SERVICE to the tail.
                    if (data_tgt_r == 19'd0) begin
                        state_nxt_s = ST_TAIL;
                    end else begin
                        state_nxt_s = ST_DATA;
                    end
                end else begin
                    phase_nxt_s = phase_cnt_r + {{(PHASE_W-1){1'b0}}, 1'b1};
                end
            end
            ST_DATA: begin
                in_bit_s = di;
                // Idle input cycles emit nothing and leave the LFSR untouched.
                if (di_vld && di_rdy_r) begin
                    emit_s = 1'b1;
                    if (data_cnt_r == (data_tgt_r - 19'd1)) begin
                        data_cnt_nxt_s = 19'd0;
                        state_nxt_s    = ST_TAIL;
                    end else begin
                        data_cnt_nxt_s = data_cnt_r + 19'd1;
                    end
                end else begin
                    emit_s = 1'b0;
                end
            end
            ST_TAIL: begin
                emit_s       = 1'b1;
                force_zero_s = 1'b1;
                if (phase_cnt_r == TAIL_LAST) begin
                    phase_nxt_s = {PHASE_W{1'b0}};
                    // Tail landing on a symbol boundary needs no padding.
                    if (sym_last_s) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_PAD;
                    end
                end else begin
                    phase_nxt_s = phase_cnt_r + {{(PHASE_W-1){1'b0}}, 1'b1};
                end
            end
            ST_PAD: begin
                emit_s = 1'b1;
                if (sym_last_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_PAD;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register and field position counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            phase_cnt_r <= {PHASE_W{1'b0}};
            data_cnt_r  <= 19'd0;
        end else begin
            state_r     <= state_nxt_s;
            phase_cnt_r <= phase_nxt_s;
            data_cnt_r  <= data_cnt_nxt_s;
        end
    end

    // Frame parameters captured at launch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ndbps_r    <= 8'd0;
            data_tgt_r <= 19'd0;
        end else if (launch_s) begin
            ndbps_r    <= ndbps_s;
            data_tgt_r <= {len, 3'b000};
        end else begin
            ndbps_r    <= ndbps_r;
            data_tgt_r <= data_tgt_r;
        end
    end

    // Scrambler state and symbol bit counter; both advance only on emitted bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_r    <= 7'h7F;
            sym_cnt_r <= 8'd0;
        end else if (launch_s) begin
            // The all-zero state would lock the LFSR, so it is replaced by all-ones.
            lfsr_r    <= (seed == 7'd0) ? 7'h7F : seed;
            sym_cnt_r <= 8'd0;
        end else if (emit_s) begin
            lfsr_r    <= {lfsr_r[5:0], fb_s};
            sym_cnt_r <= sym_last_s ? 8'd0 : (sym_cnt_r + 8'd1);
        end else begin
            lfsr_r    <= lfsr_r;
            sym_cnt_r <= sym_cnt_r;
        end
    end

    // Registered outputs; di_rdy/busy follow the next state so they line up with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout_r   <= 1'b0;
            do_vld_r <= 1'b0;
            di_rdy_r <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            dout_r   <= (emit_s && !force_zero_s) ? (in_bit_s ^ fb_s) : 1'b0;
            do_vld_r <= emit_s;
            di_rdy_r <= (state_nxt_s == ST_DATA);
            busy_r   <= (state_nxt_s != ST_IDLE);
            done_r   <= (state_r == ST_DONE);
        end
    end

    // Sticky error flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_r <= 1'b0;
        end else begin
            err_r <= err_r | err_evt_s;
        end
    end

    assign dout   = dout_r;
    assign do_vld = do_vld_r;
    assign di_rdy = di_rdy_r;
    assign busy   = busy_r;
    assign done   = done_r;
    assign err    = err_r;

endmodule

// File: tb/tb_pld_scrambler.sv
// ----------------------------------------------------------------------------
// tb_pld_scrambler
//
// Self-checking bench for pld_scrambler. A reference model builds the whole
// expected DATA-field bit sequence into a scoreboard queue when a frame is
// launched; a negedge monitor pops and compares every do_vld bit. A second
// instance with an 18-bit SERVICE field exercises the no-padding path, which
// the standard 16/6 framing can never hit.
// ----------------------------------------------------------------------------
module tb_pld_scrambler;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] len;
    logic [3:0]  rate;
    logic [6:0]  seed;
    logic        di;
    logic        di_vld;
    logic        di_rdy;
    logic        dout;
    logic        do_vld;
    logic        busy;
    logic        done;
    logic        err;

    logic        start2;
    logic        di_rdy2;
    logic        dout2;
    logic        do_vld2;
    logic        busy2;
    logic        done2;
    logic        err2;

    always #5 clk = ~clk;

    pld_scrambler dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .len    (len),
        .rate   (rate),
        .seed   (seed),
        .di     (di),
        .di_vld (di_vld),
        .di_rdy (di_rdy),
        .dout   (dout),
        .do_vld (do_vld),
        .busy   (busy),
        .done   (done),
        .err    (err)
    );

    // 18 + 0 + 6 = 24 bits: exactly one 6 Mb/s symbol, so no pad.
    pld_scrambler #(.SVC_BITS(18), .TAIL_BITS(6)) dut_np (
        .clk    (clk),
        .rst    (rst),
        .start  (start2),
        .len    (16'd0),
        .rate   (4'b1101),
        .seed   (7'h7F),
        .di     (1'b0),
        .di_vld (1'b0),
        .di_rdy (di_rdy2),
        .dout   (dout2),
        .do_vld (do_vld2),
        .busy   (busy2),
        .done   (done2),
        .err    (err2)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          vld_cnt = 0;
    int          done_cnt = 0;
    int          last_vld_cyc = 0;
    int          done_cyc = 0;
    int          cap_n = 0;
    logic [15:0] cap = 16'd0;
    int          vld2_cnt = 0;
    int          done2_cnt = 0;
    int          last2_cyc = 0;
    int          done2_cyc = 0;
    bit          ds[$];
    bit          exp_q[$];
    bit          exp_bit;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, want);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor for the main instance.
    always @(negedge clk) begin
        if (do_vld) begin
            vld_cnt++;
            last_vld_cyc = cyc;
            if (cap_n < 16) begin
                cap = {cap[14:0], dout};
                cap_n++;
            end
            if (exp_q.size() == 0) begin
                check_val("do_extra", 32'd1, 32'd0);
            end else begin
                exp_bit = exp_q.pop_front();
                check_val("do_bit", dout, exp_bit);
            end
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            check_val("busy_at_done", busy, 1'b0);
        end
    end

    // Event counter for the no-pad instance.
    always @(negedge clk) begin
        if (do_vld2) begin
            vld2_cnt++;
            last2_cyc = cyc;
        end
        if (done2) begin
            done2_cnt++;
            done2_cyc = cyc;
        end
    end

    task automatic make_data(input int l, input bit zeros);
        bit b;
        ds.delete();
        for (int i = 0; i < 8 * l; i++) begin
            b = 1'($urandom_range(1, 0));
            ds.push_back(zeros ? 1'b0 : b);
        end
    endtask

    // Reference model: SERVICE zeros, PSDU, zero tail, pad to a symbol multiple.
    task automatic build_model(input int l, input int n, input logic [6:0] s0);
        logic [6:0] s;
        logic       fb;
        int         total;
        s = s0;
        exp_q.delete();
        for (int i = 0; i < 22 + 8 * l; i++) begin
            fb = s[6] ^ s[3];
            if (i < 16) exp_q.push_back(fb);
            else if (i < 16 + 8 * l) exp_q.push_back(ds[i - 16] ^ fb);
            else exp_q.push_back(1'b0);
            s = {s[5:0], fb};
        end
        total = ((22 + 8 * l + n - 1) / n) * n;
        while (exp_q.size() < total) begin
            fb = s[6] ^ s[3];
            exp_q.push_back(fb);
            s = {s[5:0], fb};
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    // Launch one frame, feed its PSDU and check count, done timing and flags.
    task automatic run_frame(input string name, input int l, input logic [3:0] r,
                             input logic [6:0] sd, input logic [6:0] mseed, input int n,
                             input bit gappy, input bit zeros, input bit mid_start,
                             input bit want_err);
        int idx;
        int k;
        int total;
        bit phase;
        bit injected;
        make_data(l, zeros);
        build_model(l, n, mseed);
        total    = ((22 + 8 * l + n - 1) / n) * n;
        vld_cnt  = 0;
        done_cnt = 0;
        cap_n    = 0;
        cap      = 16'd0;
        start    = 1'b1;
        len      = 16'(l);
        rate     = r;
        seed     = sd;
        @(negedge clk);
        start    = 1'b0;
        idx      = 0;
        k        = 0;
        phase    = 1'b0;
        injected = 1'b0;
        while (done_cnt == 0 && k < 5000) begin
            if (di_vld) idx++;
            phase = ~phase;
            start = 1'b0;
            if (mid_start && !injected && idx == 3) begin
                start    = 1'b1;
                rate     = 4'b0001;
                injected = 1'b1;
            end
            di_vld = (idx < 8 * l) && di_rdy && (!gappy || phase);
            di     = (idx < 8 * l) ? ds[idx] : 1'b0;
            @(negedge clk);
            k++;
        end
        start  = 1'b0;
        di_vld = 1'b0;
        check_val({name, "_timeout"}, k < 5000, 1'b1);
        repeat (2) @(negedge clk);
        check_val({name, "_vld_count"}, vld_cnt, total);
        check_val({name, "_leftover"}, exp_q.size(), 0);
        check_val({name, "_done_count"}, done_cnt, 1);
        check_val({name, "_done_after_last"}, done_cyc, last_vld_cyc + 1);
        check_val({name, "_err"}, err, want_err);
        check_val({name, "_busy_idle"}, busy, 1'b0);
    endtask

    initial begin
        int k;
        int saved;
        rst    = 1'b0;
        start  = 1'b0;
        start2 = 1'b0;
        len    = 16'd0;
        rate   = 4'd0;
        seed   = 7'd0;
        di     = 1'b0;
        di_vld = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_do", dout, 1'b0);
        check_val("rst_do_vld", do_vld, 1'b0);
        check_val("rst_di_rdy", di_rdy, 1'b0);
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_done", done, 1'b0);
        check_val("rst_err", err, 1'b0);
        rst = 1'b1;
        @(negedge clk);

        run_frame("seq", 0, 4'b1101, 7'h7F, 7'h7F, 24, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("seq_first16", cap, 16'b0000111011110010);
        run_frame("len1_r24", 1, 4'b1101, 7'h35, 7'h35, 24, 1'b0, 1'b1, 1'b0, 1'b0);
        run_frame("len100_r216_gap", 100, 4'b0011, 7'h5A, 7'h5A, 216, 1'b1, 1'b0, 1'b0, 1'b0);
        run_frame("len1_r36", 1, 4'b1111, 7'h11, 7'h11, 36, 1'b0, 1'b0, 1'b0, 1'b0);

        // No-pad frame on the 18-bit SERVICE instance.
        vld2_cnt  = 0;
        done2_cnt = 0;
        start2    = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        k = 0;
        while (done2_cnt == 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        repeat (2) @(negedge clk);
        check_val("nopad_vld_count", vld2_cnt, 24);
        check_val("nopad_done_after_last", done2_cyc, last2_cyc + 1);
        check_val("nopad_done_count", done2_cnt, 1);
        check_val("nopad_err", err2, 1'b0);

        run_frame("mid_start", 2, 4'b0101, 7'h22, 7'h22, 48, 1'b0, 1'b0, 1'b1, 1'b1);

        // Invalid rate.
        do_reset();
        check_val("err_cleared", err, 1'b0);
        start = 1'b1;
        rate  = 4'b0000;
        len   = 16'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check_val("badrate_busy", busy, 1'b0);
        check_val("badrate_rdy", di_rdy, 1'b0);
        check_val("badrate_err", err, 1'b1);

        // di_vld while idle.
        do_reset();
        di_vld = 1'b1;
        @(negedge clk);
        di_vld = 1'b0;
        @(negedge clk);
        check_val("idle_dvld_err", err, 1'b1);
        check_val("idle_dvld_busy", busy, 1'b0);

        // Reset in the middle of DATA.
        do_reset();
        make_data(3, 1'b0);
        build_model(3, 96, 7'h05);
        vld_cnt = 0;
        start   = 1'b1;
        len     = 16'd3;
        rate    = 4'b1001;
        seed    = 7'h05;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!di_rdy && k < 50) begin
            @(negedge clk);
            k++;
        end
        check_val("abort_rdy_seen", di_rdy, 1'b1);
        for (int i = 0; i < 5; i++) begin
            di     = ds[i];
            di_vld = 1'b1;
            @(negedge clk);
        end
        rst    = 1'b0;
        di_vld = 1'b0;
        #1;
        check_val("abort_do", dout, 1'b0);
        check_val("abort_do_vld", do_vld, 1'b0);
        check_val("abort_di_rdy", di_rdy, 1'b0);
        check_val("abort_busy", busy, 1'b0);
        check_val("abort_done", done, 1'b0);
        check_val("abort_err", err, 1'b0);
        saved = vld_cnt;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        check_val("abort_no_vld", vld_cnt, saved);

        // Seed 0 must behave as seed 7'h7F.
        run_frame("seed0", 2, 4'b1101, 7'h00, 7'h7F, 24, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
